mem_access_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline. It is the consumer of the control bundle produced by the decode stage: mem_we, mem_read, mem_byte, mem_signextend and the store data.
- Turns that bundle plus the EX address into a req/ack transaction on the data-memory port.
- Steers byte lanes in both directions, sign- or zero-extends loads, and registers the writeback bundle.
- Raises stall while a transaction is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 23 ++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage_lane_align.sv | 45 ++++
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage.
//   memst_e  : FSM state encodings (IDLE / BUSY / DONE)
//   BE_WORD  : byte enables for a full-word access
//   BE_NONE  : no byte lanes enabled
//   lane_of  : maps the low address bits to a byte lane for a given endianness
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      MEMST_IDLE = 2'd0,
      MEMST_BUSY = 2'd1,
      MEMST_DONE = 2'd2
   } memst_e;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_NONE = 4'b0000;

   // Big-endian puts byte address 0 on bits 31:24, i.e. lane 3.
   function automatic logic [1:0] lane_of(input logic [1:0] byte_addr,
                                          input logic       big_endian);
      return big_endian ? (2'b11 - byte_addr) : byte_addr;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port.
//   master : the memory stage (drives request, address, data, byte enables)
//   slave  : the data memory (drives ack and read data)
interface mem_access_stage_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for loads and stores.
//   lane       in  2   selected byte lane (bit i covers bits 8i+7:8i)
//   is_byte    in  1   byte access; otherwise word access
//   sign_ext   in  1   sign-extend a byte load
//   store_data in  32  register value to be stored
//   load_data  in  32  raw word returned by memory
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   load_ext   out 32  extracted and extended load result
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic        is_byte,
   input  logic        sign_ext,
   input  logic [31:0] store_data,
   input  logic [31:0] load_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_ext
);

   logic [7:0] byte_s;

   // Pick the addressed byte out of the loaded word.
   always_comb begin
      byte_s = 8'h00;
      case (lane)
         2'd0:    byte_s = load_data[7:0];
         2'd1:    byte_s = load_data[15:8];
         2'd2:    byte_s = load_data[23:16];
         2'd3:    byte_s = load_data[31:24];
         default: byte_s = load_data[7:0];
      endcase
   end

   // Store steering: the byte is replicated on every lane so only be selects it.
   always_comb begin
      be       = is_byte ? (4'b0001 << lane) : BE_WORD;
      wdata    = is_byte ? {4{store_data[7:0]}} : store_data;
      load_ext = is_byte ? (sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s})
                         : load_data;
   end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Turns the decoded memory-control bundle plus the EX address into a req/ack
// transaction, steers byte lanes, extends loads and registers the writeback bundle.
//   clk, rst_n                      clock, async active-low reset
//   ex_valid, mem_we, mem_read,
//   mem_byte, mem_signextend        control bundle from EX
//   addr, write_data                effective address, store data
//   reg_we, reg_write_addr          destination info
//   dmem (master)                   data-memory port
//   stall                           freeze IF/ID/EX (combinational)
//   wb_valid, reg_we_wb,
//   reg_write_addr_wb,
//   reg_write_data_wb               registered writeback bundle
//   misaligned, bus_err             one-cycle error pulses
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_valid,
   input  logic                mem_we,
   input  logic                mem_read,
   input  logic                mem_byte,
   input  logic                mem_signextend,
   input  logic [31:0]         addr,
   input  logic [31:0]         write_data,
   input  logic                reg_we,
   input  logic [4:0]          reg_write_addr,
   mem_access_stage_if.master  dmem,
   output logic                stall,
   output logic                wb_valid,
   output logic                reg_we_wb,
   output logic [4:0]          reg_write_addr_wb,
   output logic [31:0]         reg_write_data_wb,
   output logic                misaligned,
   output logic                bus_err
);

   localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   memst_e        state_r;
   logic [CW-1:0] cnt_r;
   logic          req_r, we_r;
   logic [31:0]   addr_r, wdata_r;
   logic [3:0]    be_r;
   logic [1:0]    lat_lane_r;
   logic          lat_byte_r, lat_sext_r, lat_load_we_r;
   logic [4:0]    lat_dest_r;

   logic          busy_s, is_mem_s, misal_s, accept_s;
   logic [1:0]    aln_lane_s;
   logic          aln_byte_s, aln_sext_s;
   logic [3:0]    aln_be_s;
   logic [31:0]   aln_wdata_s, aln_load_s;

   // Decode the incoming op; a DONE cycle accepts a new op exactly like IDLE.
   always_comb begin
      busy_s   = (state_r == MEMST_BUSY);
      is_mem_s = mem_we | mem_read;
      misal_s  = ~mem_byte & (addr[1:0] != 2'b00);
      accept_s = ~busy_s & ex_valid & is_mem_s & ~misal_s;
      stall    = busy_s | accept_s;
   end

   // While busy the aligner works on the latched lane for the load result;
   // otherwise it prepares store steering for the op being accepted.
   always_comb begin
      aln_lane_s = busy_s ? lat_lane_r : lane_of(addr[1:0], BIG_ENDIAN);
      aln_byte_s = busy_s ? lat_byte_r : mem_byte;
      aln_sext_s = busy_s ? lat_sext_r : mem_signextend;
   end

   mem_lane_align u_align (
      .lane       (aln_lane_s),
      .is_byte    (aln_byte_s),
      .sign_ext   (aln_sext_s),
      .store_data (write_data),
      .load_data  (dmem.dmem_rdata),
      .be         (aln_be_s),
      .wdata      (aln_wdata_s),
      .load_ext   (aln_load_s)
   );

   assign dmem.dmem_req   = req_r;
   assign dmem.dmem_we    = we_r;
   assign dmem.dmem_addr  = addr_r;
   assign dmem.dmem_wdata = wdata_r;
   assign dmem.dmem_be    = be_r;

   // Transaction FSM with registered bus and writeback outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= MEMST_IDLE;
         cnt_r             <= '0;
         req_r             <= 1'b0;
         we_r              <= 1'b0;
         addr_r            <= 32'h0000_0000;
         wdata_r           <= 32'h0000_0000;
         be_r              <= BE_NONE;
         lat_lane_r        <= 2'b00;
         lat_byte_r        <= 1'b0;
         lat_sext_r        <= 1'b0;
         lat_load_we_r     <= 1'b0;
         lat_dest_r        <= 5'd0;
         wb_valid          <= 1'b0;
         reg_we_wb         <= 1'b0;
         reg_write_addr_wb <= 5'd0;
         reg_write_data_wb <= 32'h0000_0000;
         misaligned        <= 1'b0;
         bus_err           <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         case (state_r)
            MEMST_IDLE, MEMST_DONE: begin
               state_r <= MEMST_IDLE;
               if (ex_valid && !is_mem_s) begin
                  wb_valid          <= 1'b1;
                  reg_we_wb         <= reg_we;
                  reg_write_addr_wb <= reg_write_addr;
                  reg_write_data_wb <= addr;
               end else if (ex_valid && misal_s) begin
                  misaligned        <= 1'b1;
                  wb_valid          <= 1'b1;
                  reg_we_wb         <= 1'b0;
                  reg_write_addr_wb <= reg_write_addr;
                  reg_write_data_wb <= addr;
               end else if (accept_s) begin
                  state_r       <= MEMST_BUSY;
                  cnt_r         <= '0;
                  req_r         <= 1'b1;
                  we_r          <= mem_we;
                  addr_r        <= {addr[31:2], 2'b00};
                  wdata_r       <= aln_wdata_s;
                  be_r          <= aln_be_s;
                  lat_lane_r    <= aln_lane_s;
                  lat_byte_r    <= mem_byte;
                  lat_sext_r    <= mem_signextend;
                  // both mem_we and mem_read high counts as a store
                  lat_load_we_r <= reg_we & mem_read & ~mem_we;
                  lat_dest_r    <= reg_write_addr;
               end else begin
                  state_r <= MEMST_IDLE;
               end
            end
            MEMST_BUSY: begin
               if (dmem.dmem_ack) begin
                  state_r           <= MEMST_DONE;
                  req_r             <= 1'b0;
                  wb_valid          <= 1'b1;
                  reg_we_wb         <= lat_load_we_r;
                  reg_write_addr_wb <= lat_dest_r;
                  reg_write_data_wb <= aln_load_s;
               end else if (cnt_r == CNT_LAST) begin
                  state_r           <= MEMST_IDLE;
                  req_r             <= 1'b0;
                  bus_err           <= 1'b1;
                  wb_valid          <= 1'b1;
                  reg_we_wb         <= 1'b0;
                  reg_write_addr_wb <= lat_dest_r;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= MEMST_IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT_CYCLES=4, BIG_ENDIAN=1).
module tb_mem_access_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid, mem_we, mem_read, mem_byte, mem_signextend;
   logic [31:0] addr, write_data;
   logic        reg_we;
   logic [4:0]  reg_write_addr;
   logic        stall, wb_valid, reg_we_wb, misaligned, bus_err;
   logic [4:0]  reg_write_addr_wb;
   logic [31:0] reg_write_data_wb;

   int total = 0;
   int bad   = 0;

   mem_access_stage_if dmem_if ();

   mem_access_stage #(
      .TIMEOUT_CYCLES (4),
      .BIG_ENDIAN     (1'b1)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ex_valid          (ex_valid),
      .mem_we            (mem_we),
      .mem_read          (mem_read),
      .mem_byte          (mem_byte),
      .mem_signextend    (mem_signextend),
      .addr              (addr),
      .write_data        (write_data),
      .reg_we            (reg_we),
      .reg_write_addr    (reg_write_addr),
      .dmem              (dmem_if),
      .stall             (stall),
      .wb_valid          (wb_valid),
      .reg_we_wb         (reg_we_wb),
      .reg_write_addr_wb (reg_write_addr_wb),
      .reg_write_data_wb (reg_write_data_wb),
      .misaligned        (misaligned),
      .bus_err           (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ev, input logic we, input logic rd, input logic byt,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic rwe, input logic [4:0] dst);
      ex_valid       = ev;
      mem_we         = we;
      mem_read       = rd;
      mem_byte       = byt;
      mem_signextend = sx;
      addr           = a;
      write_data     = wd;
      reg_we         = rwe;
      reg_write_addr = dst;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
   endtask

   // Load with ack on the third busy cycle; checks stall across the whole transaction.
   task automatic load_txn(input string tag, input logic [31:0] a, input logic byt,
                           input logic sx, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data,
                           input logic [4:0] dst);
      drive(1'b1, 1'b0, 1'b1, byt, sx, a, 32'h0, 1'b1, dst);
      chk({tag, "_stall_accept"}, stall, 1);
      tick();
      idle();
      chk({tag, "_req"}, dmem_if.dmem_req, 1);
      chk({tag, "_addr"}, dmem_if.dmem_addr, exp_addr);
      chk({tag, "_we"}, dmem_if.dmem_we, 0);
      chk({tag, "_stall_b1"}, stall, 1);
      tick();
      chk({tag, "_stall_b2"}, stall, 1);
      tick();
      dmem_if.dmem_ack   = 1'b1;
      dmem_if.dmem_rdata = rdata;
      #1;
      chk({tag, "_stall_ack"}, stall, 1);
      tick();
      dmem_if.dmem_ack = 1'b0;
      #1;
      chk({tag, "_done_req"}, dmem_if.dmem_req, 0);
      chk({tag, "_done_stall"}, stall, 0);
      chk({tag, "_wb_valid"}, wb_valid, 1);
      chk({tag, "_reg_we_wb"}, reg_we_wb, 1);
      chk({tag, "_dest"}, reg_write_addr_wb, dst);
      chk({tag, "_data"}, reg_write_data_wb, exp_data);
      tick();
      chk({tag, "_wb_drop"}, wb_valid, 0);
   endtask

   initial begin
      int n;
      rst_n              = 1'b0;
      dmem_if.dmem_ack   = 1'b0;
      dmem_if.dmem_rdata = 32'h0;
      idle();
      tick();
      tick();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_req", dmem_if.dmem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_data", reg_write_data_wb, 32'h0);
      chk("rst_misal", misaligned, 0);
      chk("rst_buserr", bus_err, 0);
      rst_n = 1'b1;
      tick();

      // ADDU passthrough
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd8);
      chk("addu_stall", stall, 0);
      tick();
      idle();
      chk("addu_wb_valid", wb_valid, 1);
      chk("addu_reg_we", reg_we_wb, 1);
      chk("addu_dest", reg_write_addr_wb, 5'd8);
      chk("addu_data", reg_write_data_wb, 32'h0000_1234);
      chk("addu_stall2", stall, 0);
      chk("addu_noreq", dmem_if.dmem_req, 0);
      tick();
      chk("addu_wb_drop", wb_valid, 0);
      chk("addu_hold", reg_write_data_wb, 32'h0000_1234);

      // ack while idle must be ignored
      dmem_if.dmem_ack = 1'b1;
      tick();
      dmem_if.dmem_ack = 1'b0;
      #1;
      chk("idle_ack_wb", wb_valid, 0);
      chk("idle_ack_req", dmem_if.dmem_req, 0);

      // LB / LBU at 0x101 (big-endian lane 2 -> bits 23:16 = 0x80)
      load_txn("lb", 32'h0000_0101, 1'b1, 1'b1, 32'h1180_2233, 32'h0000_0100, 32'hFFFF_FF80, 5'd9);
      load_txn("lbu", 32'h0000_0101, 1'b1, 1'b0, 32'h1180_2233, 32'h0000_0100, 32'h0000_0080, 5'd9);

      // SB at 0x203 (lane 0), reg_we high must not leak to the writeback
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'hDEAD_BEEF, 1'b1, 5'd10);
      chk("sb_stall", stall, 1);
      tick();
      idle();
      chk("sb_req", dmem_if.dmem_req, 1);
      chk("sb_we", dmem_if.dmem_we, 1);
      chk("sb_be", dmem_if.dmem_be, 4'b0001);
      chk("sb_wdata", dmem_if.dmem_wdata, 32'hEFEF_EFEF);
      chk("sb_addr", dmem_if.dmem_addr, 32'h0000_0200);
      dmem_if.dmem_ack = 1'b1;
      tick();
      dmem_if.dmem_ack = 1'b0;
      #1;
      chk("sb_wb_valid", wb_valid, 1);
      chk("sb_reg_we_wb", reg_we_wb, 0);
      chk("sb_req_drop", dmem_if.dmem_req, 0);
      tick();

      // LW misaligned
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0302, 32'h0, 1'b1, 5'd11);
      chk("lwm_stall", stall, 0);
      tick();
      idle();
      chk("lwm_noreq", dmem_if.dmem_req, 0);
      chk("lwm_misal", misaligned, 1);
      chk("lwm_wb_valid", wb_valid, 1);
      chk("lwm_reg_we_wb", reg_we_wb, 0);
      tick();
      chk("lwm_pulse_end", misaligned, 0);

      // Aligned LW, then a second LW accepted in the DONE cycle
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 5'd12);
      tick();
      idle();
      chk("lw1_req", dmem_if.dmem_req, 1);
      chk("lw1_addr", dmem_if.dmem_addr, 32'h0000_0300);
      dmem_if.dmem_ack   = 1'b1;
      dmem_if.dmem_rdata = 32'hCAFE_F00D;
      tick();
      dmem_if.dmem_ack = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0304, 32'h0, 1'b1, 5'd13);
      chk("lw1_wb_valid", wb_valid, 1);
      chk("lw1_data", reg_write_data_wb, 32'hCAFE_F00D);
      chk("lw1_dest", reg_write_addr_wb, 5'd12);
      chk("lw2_stall_done", stall, 1);
      tick();
      idle();
      chk("lw2_req_nogap", dmem_if.dmem_req, 1);
      chk("lw2_addr", dmem_if.dmem_addr, 32'h0000_0304);
      chk("lw2_wb_drop", wb_valid, 0);
      dmem_if.dmem_ack   = 1'b1;
      dmem_if.dmem_rdata = 32'h0102_0304;
      tick();
      dmem_if.dmem_ack = 1'b0;
      #1;
      chk("lw2_data", reg_write_data_wb, 32'h0102_0304);
      chk("lw2_dest", reg_write_addr_wb, 5'd13);
      tick();

      // SW timeout: no ack ever
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h1234_5678, 1'b0, 5'd0);
      tick();
      idle();
      chk("sw_be", dmem_if.dmem_be, 4'b1111);
      chk("sw_wdata", dmem_if.dmem_wdata, 32'h1234_5678);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (dmem_if.dmem_req !== 1'b1) break;
         n++;
         tick();
      end
      chk("to_req_cycles", n, 4);
      chk("to_bus_err", bus_err, 1);
      chk("to_stall", stall, 0);
      chk("to_wb_valid", wb_valid, 1);
      chk("to_reg_we_wb", reg_we_wb, 0);
      tick();
      chk("to_pulse_end", bus_err, 0);

      // Reset mid-BUSY
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'hAAAA_5555, 1'b0, 5'd0);
      tick();
      idle();
      tick();
      chk("rb_req_busy", dmem_if.dmem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("rb_req_async", dmem_if.dmem_req, 0);
      chk("rb_wb_valid", wb_valid, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rb_no_wb", wb_valid, 0);
         chk("rb_no_req", dmem_if.dmem_req, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
